// File: rtl/mux_rr_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_rr_arbiter_pkg                                               |
// | Shared state encoding, requester count and one-hot helpers.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mux_rr_arbiter_pkg;

  localparam int NREQ = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [NREQ-1:0] C_ONEHOT_0 = 4'b0001;
  localparam logic [NREQ-1:0] C_ONEHOT_1 = 4'b0010;
  localparam logic [NREQ-1:0] C_ONEHOT_2 = 4'b0100;
  localparam logic [NREQ-1:0] C_ONEHOT_3 = 4'b1000;

  function automatic logic [NREQ-1:0] idx2onehot(input logic [1:0] idx);
    logic [NREQ-1:0] oh;
    case (idx)
      2'd0:    oh = C_ONEHOT_0;
      2'd1:    oh = C_ONEHOT_1;
      2'd2:    oh = C_ONEHOT_2;
      default: oh = C_ONEHOT_3;
    endcase
    return oh;
  endfunction

endpackage : mux_rr_arbiter_pkg
`default_nettype wire

// File: rtl/mux4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux4                                                             |
// | Single-bit 4:1 multiplexer, select index = {c1,c0}.              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mux4 (
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic c0,
  input  logic c1,
  output logic m
);

  assign m = c1 ? (c0 ? x3 : x2) : (c0 ? x1 : x0);

endmodule : mux4
`default_nettype wire

// File: rtl/mux_rr_arbiter_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick                                                          |
// | Combinational rotating-priority picker starting after last.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic            found,
  output logic [1:0]      idx
);

  logic [1:0] cand;

  // Offsets 1..4 so the previous owner is considered last.
  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_rr_arbiter                                                   |
// | Round-robin owner of a shared 4:1 mux with bounded hold time.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] x,
  output logic [NREQ-1:0] gnt,
  output logic            c0,
  output logic            c1,
  output logic            m,
  output logic            busy
);

  localparam int HOLD_W = ($clog2(MAX_HOLD) > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        last_q, last_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              m_q, m_d;

  logic              w_found;
  logic [1:0]        w_idx;
  logic [1:0]        w_pick_last;
  logic              w_release;
  logic              w_mux;

  // While granted, the pick pointer is the current owner so a release
  // re-picks on the same edge as if last_owner had already updated.
  assign w_pick_last = (state_q == ST_GRANT) ? sel_q : last_q;
  assign w_release   = !req[sel_q] || (hold_cnt_q == C_HOLD_LAST);

  rr_pick u_pick (
    .req   (req),
    .last  (w_pick_last),
    .found (w_found),
    .idx   (w_idx)
  );

  mux4 u_mux (
    .x0 (x[0]),
    .x1 (x[1]),
    .x2 (x[2]),
    .x3 (x[3]),
    .c0 (sel_q[0]),
    .c1 (sel_q[1]),
    .m  (w_mux)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    m_d        = m_q;
    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          state_d    = ST_GRANT;
          gnt_d      = idx2onehot(w_idx);
          sel_d      = w_idx;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        m_d = w_mux;
        if (w_release) begin
          last_d = sel_q;
          if (w_found) begin
            gnt_d      = idx2onehot(w_idx);
            sel_d      = w_idx;
            hold_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      sel_q      <= 2'd0;
      last_q     <= 2'd3;
      hold_cnt_q <= '0;
      m_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      m_q        <= m_d;
    end
  end

  assign gnt  = gnt_q;
  assign c0   = sel_q[0];
  assign c1   = sel_q[1];
  assign m    = m_q;
  assign busy = (state_q == ST_GRANT);

endmodule : mux_rr_arbiter
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mux_rr_arbiter                                                |
// | Directed bench over three hold limits (8, 2, 1).                 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [3:0] req8 = '0, x8 = '0, gnt8;
  logic       c0_8, c1_8, m8, busy8;
  logic [3:0] req2 = '0, x2 = '0, gnt2;
  logic       c0_2, c1_2, m2, busy2;
  logic [3:0] req1 = '0, x1 = '0, gnt1;
  logic       c0_1, c1_1, m1, busy1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_HOLD(8)) u_h8 (
    .clk(clk), .rst(rst), .req(req8), .x(x8), .gnt(gnt8),
    .c0(c0_8), .c1(c1_8), .m(m8), .busy(busy8)
  );
  mux_rr_arbiter #(.MAX_HOLD(2)) u_h2 (
    .clk(clk), .rst(rst), .req(req2), .x(x2), .gnt(gnt2),
    .c0(c0_2), .c1(c1_2), .m(m2), .busy(busy2)
  );
  mux_rr_arbiter #(.MAX_HOLD(1)) u_h1 (
    .clk(clk), .rst(rst), .req(req1), .x(x1), .gnt(gnt1),
    .c0(c0_1), .c1(c1_1), .m(m1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fair_seq [9];

  initial begin
    fair_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                 4'b0100, 4'b1000, 4'b1000, 4'b0001};

    // Reset state
    tick(); tick();
    #2 rst = 1'b0;
    check("rst_gnt",  32'(gnt8),  32'h0);
    check("rst_busy", 32'(busy8), 32'h0);
    check("rst_sel",  32'({c1_8, c0_8}), 32'h0);
    check("rst_m",    32'(m8), 32'h0);

    // Async reset mid-grant
    req8 = 4'b1111; x8 = 4'b0001;
    tick();
    check("t1_first_gnt", 32'(gnt8), 32'h1);
    check("t1_busy", 32'(busy8), 32'h1);
    tick();
    check("t1_m_set", 32'(m8), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t1_async_gnt",  32'(gnt8), 32'h0);
    check("t1_async_sel",  32'({c1_8, c0_8}), 32'h0);
    check("t1_async_m",    32'(m8), 32'h0);
    check("t1_async_busy", 32'(busy8), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t1_post_rst_gnt", 32'(gnt8), 32'h1);

    // Single requester
    req8 = 4'b0000; x8 = 4'b0000;
    tick();
    check("t2_idle_gnt", 32'(gnt8), 32'h0);
    check("t2_idle_m",   32'(m8), 32'h0);
    req8 = 4'b0100; x8 = 4'b0100;
    tick();
    check("t2_gnt",  32'(gnt8), 32'h4);
    check("t2_sel",  32'({c1_8, c0_8}), 32'h2);
    check("t2_busy", 32'(busy8), 32'h1);
    check("t2_m_lag", 32'(m8), 32'h0);
    tick();
    check("t2_m", 32'(m8), 32'h1);
    req8 = 4'b0000;
    tick();
    check("t2_drop_gnt",  32'(gnt8), 32'h0);
    check("t2_drop_busy", 32'(busy8), 32'h0);
    check("t2_drop_m",    32'(m8), 32'h1);

    // Pointer rotation (last owner is 2)
    req8 = 4'b0001;
    tick();
    check("t5_gnt0", 32'(gnt8), 32'h1);
    req8 = 4'b1000;
    tick();
    check("t5_gnt3", 32'(gnt8), 32'h8);
    check("t5_busy", 32'(busy8), 32'h1);
    req8 = 4'b1001;
    tick();
    check("t5_hold_owner", 32'(gnt8), 32'h8);
    req8 = 4'b0001;
    tick();
    check("t5_gnt0_again", 32'(gnt8), 32'h1);
    check("t5_sel", 32'({c1_8, c0_8}), 32'h0);

    // Sole requester timeout with MAX_HOLD=8
    req8 = 4'b0000;
    tick();
    check("t4_idle", 32'(busy8), 32'h0);
    req8 = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("t4_gnt_%0d", k),  32'(gnt8), 32'h2);
      check($sformatf("t4_busy_%0d", k), 32'(busy8), 32'h1);
      check($sformatf("t4_hold_%0d", k), 32'(u_h8.hold_cnt_q), 32'((k - 1) % 8));
    end

    // Fairness with MAX_HOLD=2
    req2 = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("t3_gnt_%0d", k),  32'(gnt2), 32'(fair_seq[k]));
      check($sformatf("t3_busy_%0d", k), 32'(busy2), 32'h1);
    end

    // Per-cycle rotation with MAX_HOLD=1
    req1 = 4'b0101; x1 = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("t6_gnt_%0d", k), 32'(gnt1), (k % 2 == 1) ? 32'h1 : 32'h4);
      check($sformatf("t6_m_%0d", k),   32'(m1),   (k % 2 == 0) ? 32'h1 : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux_rr_arbiter
`default_nettype wire
